// File: rtl/net_arbiter_pkg.sv
// net_pkg: shared types and constants for the net engine arbiter.
// Holds the FSM state encoding, word width and float32 constants.
package net_pkg;

    localparam int W = 32;

    localparam logic [31:0] F_ZERO = 32'h0000_0000;
    localparam logic [31:0] F_ONE  = 32'h3f80_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_RELEASE,
        S_WAIT,
        S_RESP
    } state_t;

    // clog2 that never yields a zero-width field
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/net_arbiter_if.sv
// net_arbiter_if: client request/response bus plus engine control bus.
// master = arbiter side; slave = clients and engine side.
interface net_arbiter_if
    import net_pkg::*;
#(
    parameter int R = 4,
    parameter int I = 2,
    parameter int O = 1,
    parameter int W = 32
);
    localparam int IDW = clog2_min1(R);

    logic [R-1:0]     req;
    logic [R*W*I-1:0] req_x;
    logic [R-1:0]     req_ack;
    logic             busy;
    logic             rsp_valid;
    logic [IDW-1:0]   rsp_id;
    logic [W*O-1:0]   rsp_y;
    logic             rsp_err;
    logic             net_start;
    logic             net_rst_n;
    logic [W*I-1:0]   net_x;
    logic [W*O-1:0]   net_y;
    logic             net_done;

    modport master (
        input  req, req_x, net_y, net_done,
        output req_ack, busy, rsp_valid, rsp_id,
        output rsp_y, rsp_err,
        output net_start, net_rst_n, net_x
    );

    modport slave (
        output req, req_x, net_y, net_done,
        input  req_ack, busy, rsp_valid, rsp_id,
        input  rsp_y, rsp_err,
        input  net_start, net_rst_n, net_x
    );

endinterface

// File: rtl/net_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Ports: req (R requests), last (previous grant) -> grant_idx, any.
module rr_pick
    import net_pkg::*;
#(
    parameter  int R   = 4,
    localparam int IDW = clog2_min1(R)
) (
    input  logic [R-1:0]   req,
    input  logic [IDW-1:0] last,
    output logic [IDW-1:0] grant_idx,
    output logic           any
);

    function automatic int wrap(input int v);
        return (v >= R) ? v - R : v;
    endfunction

    // Scan from the far end down so the nearest set bit
    // after 'last' is the final assignment.
    always_comb begin
        grant_idx = '0;
        any       = |req;
        for (int i = R; i >= 1; i--) begin
            if (req[IDW'(wrap(int'(last) + i))])
                grant_idx = IDW'(wrap(int'(last) + i));
        end
    end

endmodule

// File: rtl/net_arbiter.sv
// net_arbiter: shares one net engine among R requesters (round-robin).
// Ports: clk, rst (async, active high), bus (net_arbiter_if.master).
module net_arbiter
    import net_pkg::*;
#(
    parameter int R       = 4,
    parameter int I       = 2,
    parameter int O       = 1,
    parameter int W       = net_pkg::W,
    parameter int TIMEOUT = 1024
) (
    input logic          clk,
    input logic          rst,
    net_arbiter_if.master bus
);

    localparam int IDW = clog2_min1(R);
    localparam int CW  = clog2_min1(TIMEOUT);

    state_t           state;
    logic [R-1:0]     ack_q;
    logic             busy_q;
    logic             rsp_valid_q;
    logic [IDW-1:0]   id_q;
    logic [IDW-1:0]   last_q;
    logic [W*O-1:0]   y_q;
    logic             err_q;
    logic             start_q;
    logic             net_rst_n_q;
    logic [W*I-1:0]   x_q;
    logic             done_q;
    logic             rst_hold;
    logic [CW-1:0]    cnt;

    logic [IDW-1:0]   grant_idx;
    logic             any;
    logic             done_rise;

    rr_pick #(.R(R)) u_pick (
        .req       (bus.req),
        .last      (last_q),
        .grant_idx (grant_idx),
        .any       (any)
    );

    assign done_rise = bus.net_done & ~done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            ack_q       <= '0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            id_q        <= '0;
            last_q      <= IDW'(R - 1);
            y_q         <= '0;
            err_q       <= 1'b0;
            start_q     <= 1'b0;
            net_rst_n_q <= 1'b0;
            x_q         <= '0;
            done_q      <= 1'b0;
            rst_hold    <= 1'b1;
            cnt         <= '0;
        end else begin
            done_q      <= bus.net_done;
            rst_hold    <= 1'b0;
            ack_q       <= '0;
            rsp_valid_q <= 1'b0;
            start_q     <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (any) begin
                        state       <= S_LAUNCH;
                        busy_q      <= 1'b1;
                        ack_q       <= R'(1) << grant_idx;
                        start_q     <= 1'b1;
                        net_rst_n_q <= 1'b0;
                        x_q         <= bus.req_x[int'(grant_idx) * (W * I) +: W * I];
                        id_q        <= grant_idx;
                        last_q      <= grant_idx;
                    end else begin
                        // engine stays in reset for one cycle after rst drops
                        net_rst_n_q <= ~rst_hold;
                    end
                end
                S_LAUNCH: begin
                    state       <= S_RELEASE;
                    net_rst_n_q <= 1'b1;
                    cnt         <= '0;
                end
                S_RELEASE: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (done_rise) begin
                        y_q         <= bus.net_y;
                        err_q       <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state       <= S_RESP;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        y_q         <= {O{W'(F_ZERO)}};
                        err_q       <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        net_rst_n_q <= 1'b0;
                        state       <= S_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    state       <= S_IDLE;
                    busy_q      <= 1'b0;
                    net_rst_n_q <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ack   = ack_q;
    assign bus.busy      = busy_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_y     = y_q;
    assign bus.rsp_err   = err_q;
    assign bus.net_start = start_q;
    assign bus.net_rst_n = net_rst_n_q;
    assign bus.net_x     = x_q;

endmodule

// File: tb/tb_net_arbiter.sv
// tb_net_arbiter: randomized bench for net_arbiter with an XOR engine stub.
// Round-robin order and XOR results come from a queue-free arithmetic model.
module tb_net_arbiter;
    import net_pkg::*;

    localparam int R  = 4;
    localparam int I  = 2;
    localparam int O  = 1;
    localparam int TO = 16;
    localparam int XW = W * I;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    net_arbiter_if #(.R(R), .I(I), .O(O), .W(W)) bus ();

    net_arbiter #(
        .R(R), .I(I), .O(O), .W(W), .TIMEOUT(TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vecs = 0;
    int errs = 0;

    // engine stub: 0 = XOR after lat cycles, 1 = never done, 2 = manual
    int          eng_mode;
    int          lat;
    int          ecnt;
    logic        eng_done;
    logic [31:0] eng_y;
    logic        man_done;
    logic [31:0] man_y;

    function automatic logic [31:0] xor_f(input logic [63:0] x);
        logic a, b;
        a = |x[30:0];
        b = |x[62:32];
        return (a ^ b) ? F_ONE : F_ZERO;
    endfunction

    always @(posedge clk) begin
        if (bus.net_rst_n !== 1'b1) begin
            ecnt     <= 0;
            eng_done <= 1'b0;
            eng_y    <= '0;
        end else if (eng_mode == 0) begin
            if (ecnt >= lat) begin
                eng_done <= 1'b1;
                eng_y    <= xor_f(bus.net_x);
            end else begin
                ecnt <= ecnt + 1;
            end
        end
    end

    assign bus.net_done = (eng_mode == 2) ? man_done : eng_done;
    assign bus.net_y    = (eng_mode == 2) ? man_y : eng_y;

    // reference model state
    int           m_last;
    logic [R-1:0] pend;
    logic [63:0]  mx [R];

    function automatic int rr_exp(input logic [R-1:0] p, input int last);
        for (int i = 1; i <= R; i++) begin
            if (p[(last + i) % R]) return (last + i) % R;
        end
        return -1;
    endfunction

    function automatic logic [31:0] rnd_f();
        return ($urandom_range(0, 1) != 0) ? F_ONE : F_ZERO;
    endfunction

    task automatic set_req(input int k, input logic [31:0] x0,
                           input logic [31:0] x1);
        bus.req_x[k * XW +: XW] = {x1, x0};
        bus.req[k] = 1'b1;
        mx[k]      = {x1, x0};
        pend[k]    = 1'b1;
    endtask

    // Runs until a response strobe; clients drop req on their ack.
    task automatic wait_rsp(input int budget, output bit got,
                            output int ack_n, output logic [R-1:0] ack_raw,
                            output int ack_at, output int rsp_at);
        got = 0; ack_n = 0; ack_raw = '0; ack_at = -1; rsp_at = -1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (bus.req_ack != '0) begin
                ack_n++;
                ack_raw = bus.req_ack;
                ack_at  = c;
                bus.req = bus.req & ~bus.req_ack;
            end
            if (bus.rsp_valid === 1'b1) begin
                got    = 1;
                rsp_at = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [255:0] outs;
        rst = 1'b1;
        bus.req = '0; bus.req_x = '0;
        eng_mode = 0; lat = 2;
        man_done = 1'b0; man_y = '0;
        pend = '0;
        repeat (3) @(negedge clk);
        outs = 256'({bus.req_ack, bus.busy, bus.rsp_valid, bus.rsp_id,
                     bus.rsp_y, bus.rsp_err, bus.net_start,
                     bus.net_rst_n, bus.net_x});
        vecs++;
        if (outs !== '0) begin
            errs++; $display("FAIL reset_outs got %h want 0", outs);
        end
        rst = 1'b0;
        m_last = R - 1;
        @(negedge clk);
        vecs++;
        if (bus.net_rst_n !== 1'b0) begin
            errs++; $display("FAIL rst_n_hold got %b want 0", bus.net_rst_n);
        end
        @(negedge clk);
        vecs++;
        if ({bus.net_rst_n, bus.busy} !== 2'b10) begin
            errs++; $display("FAIL rst_n_release got %b want 10",
                             {bus.net_rst_n, bus.busy});
        end
    endtask

    task automatic test_single();
        bit got; int n, aat, rat;
        logic [R-1:0] ar;
        lat = $urandom_range(1, 4);
        set_req(0, F_ZERO, F_ZERO);
        wait_rsp(40, got, n, ar, aat, rat);
        pend[0] = 1'b0; m_last = 0;
        vecs++;
        if (!got || ar !== 4'b0001 || aat != 1) begin
            errs++; $display("FAIL single0_ack got %b at %0d want 0001 at 1",
                             ar, aat);
        end
        vecs++;
        if ({bus.rsp_id, bus.rsp_y, bus.rsp_err} !== {2'd0, F_ZERO, 1'b0}) begin
            errs++; $display("FAIL single0_rsp got id %0d y %h err %b want 0 %h 0",
                             bus.rsp_id, bus.rsp_y, bus.rsp_err, F_ZERO);
        end
        lat = $urandom_range(1, 4);
        set_req(2, F_ONE, F_ZERO);
        wait_rsp(40, got, n, ar, aat, rat);
        pend[2] = 1'b0; m_last = 2;
        vecs++;
        if (!got || {bus.rsp_id, bus.rsp_y, bus.rsp_err} !== {2'd2, F_ONE, 1'b0}) begin
            errs++; $display("FAIL single2_rsp got id %0d y %h err %b want 2 %h 0",
                             bus.rsp_id, bus.rsp_y, bus.rsp_err, F_ONE);
        end
    endtask

    // one job: model predicts grant and XOR result
    task automatic serve_one(input string tag);
        bit got; int n, aat, rat, e;
        logic [R-1:0] ar;
        e = rr_exp(pend, m_last);
        lat = $urandom_range(1, 6);
        wait_rsp(60, got, n, ar, aat, rat);
        vecs++;
        if (!got || n != 1 || ar !== (R'(1) << e)) begin
            errs++; $display("FAIL %s_ack got %b x%0d want %b x1",
                             tag, ar, n, R'(1) << e);
        end
        vecs++;
        if (int'(bus.rsp_id) != e || bus.rsp_y !== xor_f(mx[e])
            || bus.rsp_err !== 1'b0) begin
            errs++; $display("FAIL %s_rsp got id %0d y %h want id %0d y %h",
                             tag, bus.rsp_id, bus.rsp_y, e, xor_f(mx[e]));
        end
        m_last = e;
        pend[e] = 1'b0;
    endtask

    task automatic test_contention();
        @(negedge clk);
        set_req(0, F_ZERO, F_ZERO);
        set_req(1, F_ZERO, F_ONE);
        set_req(2, F_ONE, F_ZERO);
        set_req(3, F_ONE, F_ONE);
        for (int j = 0; j < 5; j++) begin
            serve_one("contend");
            if (j == 3) set_req(0, F_ONE, F_ZERO);
        end
    endtask

    task automatic test_random();
        for (int j = 0; j < 12; j++) begin
            for (int k = 0; k < R; k++) begin
                if (!pend[k] && $urandom_range(0, 1) != 0)
                    set_req(k, rnd_f(), rnd_f());
            end
            if (pend == '0) set_req(int'($urandom_range(0, R - 1)),
                                    rnd_f(), rnd_f());
            serve_one("random");
        end
        // drain whatever is still pending
        while (pend != '0) serve_one("drain");
    endtask

    task automatic test_launch();
        logic [63:0] x;
        bit got; int bad;
        x = {F_ONE, F_ONE};
        @(negedge clk);
        set_req(1, F_ONE, F_ONE);
        @(negedge clk);
        vecs++;
        if ({bus.req_ack, bus.net_start, bus.net_rst_n, bus.busy}
            !== {4'b0010, 1'b1, 1'b0, 1'b1} || bus.net_x !== x) begin
            errs++; $display("FAIL launch got ack %b st %b rn %b x %h",
                             bus.req_ack, bus.net_start, bus.net_rst_n, bus.net_x);
        end
        bus.req[1] = 1'b0;
        bus.req_x[1 * XW +: XW] = {$urandom, $urandom};
        @(negedge clk);
        vecs++;
        if ({bus.req_ack, bus.net_start, bus.net_rst_n} !== {4'b0000, 1'b0, 1'b1}) begin
            errs++; $display("FAIL release got ack %b st %b rn %b want 0000 0 1",
                             bus.req_ack, bus.net_start, bus.net_rst_n);
        end
        got = 0; bad = 0;
        for (int c = 0; c < 30 && !got; c++) begin
            @(negedge clk);
            if (bus.net_x !== x) bad++;
            if (bus.rsp_valid === 1'b1) got = 1;
        end
        vecs++;
        if (!got || bad != 0 || bus.rsp_y !== F_ZERO) begin
            errs++; $display("FAIL net_x_stable got %0d changes y %h want 0 %h",
                             bad, bus.rsp_y, F_ZERO);
        end
        pend[1] = 1'b0; m_last = 1;
    endtask

    task automatic test_timeout();
        bit got; int n, aat, rat;
        logic [R-1:0] ar;
        @(negedge clk);
        eng_mode = 1;
        set_req(3, F_ONE, F_ZERO);
        wait_rsp(80, got, n, ar, aat, rat);
        pend[3] = 1'b0; m_last = 3;
        // ack cycle, release, TO wait cycles, then the strobe
        vecs++;
        if (!got || rat - aat != TO + 2) begin
            errs++; $display("FAIL timeout_lat got %0d want %0d", rat - aat, TO + 2);
        end
        vecs++;
        if ({bus.rsp_id, bus.rsp_y, bus.rsp_err, bus.net_rst_n}
            !== {2'd3, F_ZERO, 1'b1, 1'b0}) begin
            errs++; $display("FAIL timeout_rsp got id %0d y %h err %b rn %b",
                             bus.rsp_id, bus.rsp_y, bus.rsp_err, bus.net_rst_n);
        end
        eng_mode = 0;
        @(negedge clk);
        vecs++;
        if (bus.net_rst_n !== 1'b1) begin
            errs++; $display("FAIL abort_pulse got rn %b want 1", bus.net_rst_n);
        end
        set_req(0, F_ONE, F_ZERO);
        serve_one("after_timeout");
    endtask

    task automatic test_stale();
        int early;
        @(negedge clk);
        eng_mode = 2;
        man_done = 1'b1;
        man_y = F_ZERO;
        set_req(2, F_ONE, F_ZERO);
        @(negedge clk);
        vecs++;
        if (bus.req_ack !== 4'b0100) begin
            errs++; $display("FAIL stale_ack got %b want 0100", bus.req_ack);
        end
        bus.req[2] = 1'b0;
        early = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0) early++;
        end
        man_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0) early++;
        end
        vecs++;
        if (early != 0) begin
            errs++; $display("FAIL stale_ignored got %0d early strobes want 0", early);
        end
        man_done = 1'b1;
        man_y = F_ONE;
        @(negedge clk);
        vecs++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_y, bus.rsp_err}
            !== {1'b1, 2'd2, F_ONE, 1'b0}) begin
            errs++; $display("FAIL stale_edge got v %b id %0d y %h err %b",
                             bus.rsp_valid, bus.rsp_id, bus.rsp_y, bus.rsp_err);
        end
        pend[2] = 1'b0; m_last = 2;
        eng_mode = 0;
        man_done = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [255:0] outs;
        @(negedge clk);
        eng_mode = 1;
        set_req(0, F_ONE, F_ONE);
        @(negedge clk);
        bus.req[0] = 1'b0;
        pend[0] = 1'b0;
        repeat (3) @(negedge clk);
        set_req(1, F_ZERO, F_ONE);
        set_req(3, F_ONE, F_ONE);
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            outs = 256'({bus.req_ack, bus.busy, bus.rsp_valid, bus.rsp_id,
                         bus.rsp_y, bus.rsp_err, bus.net_start,
                         bus.net_rst_n, bus.net_x});
            vecs++;
            if (outs !== '0) begin
                errs++; $display("FAIL midrst_outs got %h want 0", outs);
            end
        end
        rst = 1'b0;
        eng_mode = 0;
        m_last = R - 1;
        serve_one("post_reset_first");
        serve_one("post_reset_second");
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_random();
        test_launch();
        test_timeout();
        test_stale();
        test_reset_mid();
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
